reg_file_mp: RTL and testbench

//  Parametrised multi-port register file: NUM_REGS x DATA_W storage, one write port, two registered read ports.

---
 rtl/reg_file_pkg.sv | 27 ++
 rtl/rf_read_port.sv | 62 ++++++
 rtl/reg_file_mp.sv | 123 ++++++++++++
 tb/tb_reg_file_mp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-engine state encoding and the address-width helpers.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // A one-register file still needs a one-bit address bus.
    function automatic int addr_width(input int num_regs);
        return (clog2(num_regs) < 1) ? 1 : clog2(num_regs);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range/zero-register check, optional write-through, output registers.
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle accepted write to the read data.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 16,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = addr_width(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_en,
    input  logic [ADDR_W-1:0]                rd_addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic                             wr_accept,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             rd_valid
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

    logic              in_range;
    logic              is_zero;
    logic [DATA_W-1:0] next_data;

    assign in_range = ({1'b0, rd_addr} < NUM_REGS_W);
    assign is_zero  = (ZERO_REG != 0) && (rd_addr == '0);

    // Out-of-range and hardwired-zero reads return 0; the zero check also blocks the bypass.
    always_comb begin
        next_data = '0;
        if (in_range && !is_zero) begin
            if (BYPASS && wr_accept && (wr_addr == rd_addr)) begin
                next_data = wr_data;
            end else begin
                next_data = regs[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= next_data;
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: one write port, two registered read ports, sequential bulk clear.
// Build option: REGFILE_BYPASS_EN enables same-cycle write-through on the read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 16,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = addr_width(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_drop,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_valid1,
    input  logic              rd_en2,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid2
);

    localparam logic [ADDR_W:0]   NUM_REGS_W = NUM_REGS[ADDR_W:0];
    localparam int                LAST_INT   = NUM_REGS - 1;
    localparam logic [ADDR_W-1:0] LAST_IDX   = LAST_INT[ADDR_W-1:0];

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    clr_state_t                      state;
    logic [ADDR_W-1:0]               cnt;
    logic                            wr_in_range;
    logic                            wr_is_zero;
    logic                            wr_accept;

    assign wr_in_range = ({1'b0, wr_addr} < NUM_REGS_W);
    assign wr_is_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_accept   = wr_en && (state == IDLE) && wr_in_range && !wr_is_zero;

    // Writes only land while idle, so a write in the clr_req cycle is later wiped by the sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_accept) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && ((state != IDLE) || !wr_in_range);
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    rf_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG)
    ) u_port1 (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en1),
        .rd_addr  (rd_addr1),
        .regs     (regs),
        .wr_accept(wr_accept),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data1),
        .rd_valid (rd_valid1)
    );

    rf_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG)
    ) u_port2 (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en2),
        .rd_addr  (rd_addr2),
        .regs     (regs),
        .wr_accept(wr_accept),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data2),
        .rd_valid (rd_valid2)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (NUM_REGS=12, ZERO_REG=1), directed plus random stimulus.
// Expectations follow REGFILE_BYPASS_EN when the macro is defined for the build.
module tb_reg_file_mp;

    localparam int N  = 12;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam bit ZR = 1'b1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr_req = 1'b0;
    logic          busy;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_drop;
    logic          rd_en1 = 1'b0;
    logic [AW-1:0] rd_addr1 = '0;
    logic [DW-1:0] rd_data1;
    logic          rd_valid1;
    logic          rd_en2 = 1'b0;
    logic [AW-1:0] rd_addr2 = '0;
    logic [DW-1:0] rd_data2;
    logic          rd_valid2;

    int checks = 0;
    int errors = 0;

    reg_file_mp #(.DATA_W(DW), .NUM_REGS(N), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_drop  (wr_drop),
        .rd_en1   (rd_en1),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_valid1(rd_valid1),
        .rd_en2   (rd_en2),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .rd_valid2(rd_valid2)
    );

    always #5 clk = ~clk;

    // Reference model: register contents as a plain array, clear as "registers left to wipe".
    logic [DW-1:0] m_regs [N];
    int            m_clear_left = 0;
    bit            m_acc;
    logic [DW-1:0] exp_data1 = '0;
    logic [DW-1:0] exp_data2 = '0;
    bit            exp_valid1 = 1'b0;
    bit            exp_valid2 = 1'b0;
    bit            exp_drop = 1'b0;
    bit            exp_busy = 1'b0;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit acc);
        if (int'(a) >= N || (ZR && a == '0)) return '0;
        if (BYP && acc && a == wr_addr) return wr_data;
        return m_regs[int'(a)];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_clear_left = 0;
            exp_data1 = '0; exp_data2 = '0;
            exp_valid1 = 1'b0; exp_valid2 = 1'b0;
            exp_drop = 1'b0; exp_busy = 1'b0;
        end else begin
            m_acc = wr_en && (m_clear_left == 0) && (int'(wr_addr) < N) && !(ZR && wr_addr == '0);
            exp_drop = wr_en && ((m_clear_left != 0) || (int'(wr_addr) >= N));
            exp_valid1 = rd_en1;
            exp_valid2 = rd_en2;
            if (rd_en1) exp_data1 = model_read(rd_addr1, m_acc);
            if (rd_en2) exp_data2 = model_read(rd_addr2, m_acc);
            if (m_clear_left != 0) begin
                m_regs[N - m_clear_left] = '0;
                m_clear_left--;
            end else begin
                if (m_acc) m_regs[int'(wr_addr)] = wr_data;
                if (clr_req) m_clear_left = N;
            end
            exp_busy = (m_clear_left != 0);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("rd_data1",  32'(rd_data1),  32'(exp_data1));
        check_output("rd_valid1", 32'(rd_valid1), 32'(exp_valid1));
        check_output("rd_data2",  32'(rd_data2),  32'(exp_data2));
        check_output("rd_valid2", 32'(rd_valid2), 32'(exp_valid2));
        check_output("wr_drop",   32'(wr_drop),   32'(exp_drop));
        check_output("busy",      32'(busy),      32'(exp_busy));
    end

    task automatic apply_stimulus(input bit we, input int wa, input logic [DW-1:0] wd,
                                  input bit r1, input int a1, input bit r2, input int a2,
                                  input bit clr);
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        rd_en1   = r1;
        rd_addr1 = AW'(a1);
        rd_en2   = r2;
        rd_addr2 = AW'(a2);
        clr_req  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    int busy_cycles;

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_valid1", 32'(rd_valid1), 32'd0);

        // All registers read back zero after reset, on both ports.
        for (int i = 0; i < N; i++) apply_stimulus(1'b0, 0, '0, 1'b1, i, 1'b1, N - 1 - i, 1'b0);
        check_output("reset_read_valid2", 32'(rd_valid2), 32'd1);

        apply_stimulus(1'b1, 5, 16'hBEEF, 1'b0, 0, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 0, '0, 1'b1, 5, 1'b0, 0, 1'b0);
        check_output("r5_data", 32'(rd_data1), 32'h0000BEEF);
        check_output("r5_valid", 32'(rd_valid1), 32'd1);
        idle_cycle();
        check_output("r5_hold_data", 32'(rd_data1), 32'h0000BEEF);
        check_output("r5_hold_valid", 32'(rd_valid1), 32'd0);

        apply_stimulus(1'b1, 3, 16'hAAAA, 1'b0, 0, 1'b0, 0, 1'b0);
        apply_stimulus(1'b1, 3, 16'h1234, 1'b0, 0, 1'b1, 3, 1'b0);
        check_output("r3_same_cycle", 32'(rd_data2), BYP ? 32'h1234 : 32'hAAAA);
        apply_stimulus(1'b0, 0, '0, 1'b0, 0, 1'b1, 3, 1'b0);
        check_output("r3_after", 32'(rd_data2), 32'h1234);

        apply_stimulus(1'b1, 0, 16'hFFFF, 1'b1, 0, 1'b0, 0, 1'b0);
        check_output("r0_same_cycle", 32'(rd_data1), 32'h0);
        apply_stimulus(1'b0, 0, '0, 1'b1, 0, 1'b0, 0, 1'b0);
        check_output("r0_drop", 32'(wr_drop), 32'd0);
        check_output("r0_data", 32'(rd_data1), 32'h0);

        apply_stimulus(1'b1, 13, 16'h7777, 1'b0, 0, 1'b0, 0, 1'b0);
        check_output("oor_drop", 32'(wr_drop), 32'd1);
        apply_stimulus(1'b0, 0, '0, 1'b1, 13, 1'b0, 0, 1'b0);
        check_output("oor_read_data", 32'(rd_data1), 32'h0);
        check_output("oor_read_valid", 32'(rd_valid1), 32'd1);

        for (int i = 1; i < N; i++) apply_stimulus(1'b1, i, DW'(i * 16'h1111), 1'b0, 0, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b1);
        busy_cycles = busy ? 1 : 0;
        apply_stimulus(1'b1, 2, 16'h5555, 1'b0, 0, 1'b0, 0, 1'b0);
        if (busy) busy_cycles++;
        check_output("busy_write_drop", 32'(wr_drop), 32'd1);
        for (int i = 0; i < 64 && busy; i++) begin
            idle_cycle();
            if (busy) busy_cycles++;
        end
        check_output("clear_busy_cycles", 32'(busy_cycles), 32'(N));
        check_output("clear_done", 32'(busy), 32'd0);
        for (int i = 0; i < N; i++) apply_stimulus(1'b0, 0, '0, 1'b1, i, 1'b1, i, 1'b0);
        apply_stimulus(1'b0, 0, '0, 1'b1, 2, 1'b0, 0, 1'b0);
        check_output("r2_after_clear", 32'(rd_data1), 32'h0);

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), DW'($urandom),
                           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                           ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 2 * N; i++) idle_cycle();

        for (int i = 1; i < N; i++) apply_stimulus(1'b1, i, 16'hC3C3, 1'b0, 0, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1'b1);
        repeat (3) idle_cycle();
        check_output("mid_clear_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) apply_stimulus(1'b0, 0, '0, 1'b1, i, 1'b1, i, 1'b0);
        apply_stimulus(1'b0, 0, '0, 1'b1, 11, 1'b0, 0, 1'b0);
        check_output("r11_after_abort", 32'(rd_data1), 32'h0);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
